// File: rtl/nearest_pkg.sv
// Shared types and helpers for the nearest-match search controller.
// absDiff works on a 32-bit container so any WIDTH up to 32 can share it.
package nearest_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam int ABS_W = 32;

   function automatic logic [ABS_W-1:0] absDiff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/nearest_select.sv
// Two-input closest-to-reference comparator; on equal distance dataA is kept,
// so the earlier candidate wins when the controller feeds best into dataA.
module nearest_select
   import nearest_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [WIDTH-1:0] refI,
   output logic [WIDTH-1:0] result,
   output logic             takeB
);

   logic [ABS_W-1:0] distA;
   logic [ABS_W-1:0] distB;

   assign distA  = absDiff(ABS_W'(dataA), ABS_W'(refI));
   assign distB  = absDiff(ABS_W'(dataB), ABS_W'(refI));
   assign takeB  = (distB < distA);
   assign result = takeB ? dataB : dataA;

endmodule

// File: rtl/nearest_search_ctrl.sv
// Sequential nearest-match search: streams up to MAX_N candidates through one
// shared comparator, keeping the running best and its arrival index.
module nearest_search_ctrl
   import nearest_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MAX_N = 16,
   parameter int CW    = $clog2(MAX_N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] refIn,
   input  logic [CW-1:0]    count,
   input  logic             inValid,
   input  logic [WIDTH-1:0] inData,
   output logic             inReady,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [WIDTH-1:0] best,
   output logic [CW-1:0]    bestIdx
);

   state_t           state;
   logic [WIDTH-1:0] refReg;
   logic [CW-1:0]    target;
   logic [CW-1:0]    idxCnt;
   logic [CW-1:0]    satCount;
   logic [WIDTH-1:0] selResult;
   logic             selTakeB;
   logic             transfer;

   assign satCount = (count > CW'(MAX_N)) ? CW'(MAX_N) : count;
   assign transfer = (state == SCAN) && inValid;

   nearest_select #(.WIDTH(WIDTH)) uSelect (
      .dataA  (best),
      .dataB  (inData),
      .refI   (refReg),
      .result (selResult),
      .takeB  (selTakeB)
   );

   // One FSM owns every register so the status outputs stay glitch-free flops;
   // the first transfer of a search bypasses the comparator since best is empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         refReg  <= '0;
         target  <= '0;
         idxCnt  <= '0;
         inReady <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         found   <= 1'b0;
         best    <= '0;
         bestIdx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  refReg  <= refIn;
                  target  <= satCount;
                  idxCnt  <= '0;
                  best    <= '0;
                  bestIdx <= '0;
                  found   <= 1'b0;
                  busy    <= 1'b1;
                  if (satCount == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= SCAN;
                     inReady <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (transfer) begin
                  if (idxCnt == '0) begin
                     best    <= inData;
                     bestIdx <= idxCnt;
                  end else begin
                     best <= selResult;
                     if (selTakeB) begin
                        bestIdx <= idxCnt;
                     end
                  end
                  idxCnt <= idxCnt + CW'(1);
                  if (idxCnt + CW'(1) == target) begin
                     state   <= DONE;
                     inReady <= 1'b0;
                     done    <= 1'b1;
                     found   <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               inReady <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nearest_search_ctrl.sv
// Directed bench for nearest_search_ctrl: expected results come from a small
// reference model, queued at start and compared when done pulses.
module tb_nearest_search_ctrl;

   localparam int WIDTH = 8;
   localparam int MAX_N = 16;
   localparam int CW    = $clog2(MAX_N + 1);

   typedef struct packed {
      logic [WIDTH-1:0] best;
      logic [CW-1:0]    idx;
      logic             found;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] refIn;
   logic [CW-1:0]    count;
   logic             inValid;
   logic [WIDTH-1:0] inData;
   logic             inReady;
   logic             busy;
   logic             done;
   logic             found;
   logic [WIDTH-1:0] best;
   logic [CW-1:0]    bestIdx;

   exp_t expQ[$];
   int   checks;
   int   errors;

   nearest_search_ctrl #(.WIDTH(WIDTH), .MAX_N(MAX_N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .refIn   (refIn),
      .count   (count),
      .inValid (inValid),
      .inData  (inData),
      .inReady (inReady),
      .busy    (busy),
      .done    (done),
      .found   (found),
      .best    (best),
      .bestIdx (bestIdx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int distOf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] r);
      int xi;
      int ri;
      xi = int'(x);
      ri = int'(r);
      return (xi >= ri) ? (xi - ri) : (ri - xi);
   endfunction

   // Reference model: first candidate seeds, strictly closer later ones replace it.
   function automatic exp_t model(input logic [WIDTH-1:0] r, input int n,
                                  input logic [WIDTH-1:0] c[$]);
      exp_t e;
      e = '0;
      if (n > 0) begin
         e.best  = c[0];
         e.idx   = '0;
         e.found = 1'b1;
         for (int i = 1; i < n; i++) begin
            if (distOf(c[i], r) < distOf(e.best, r)) begin
               e.best = c[i];
               e.idx  = CW'(i);
            end
         end
      end
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Runs one search; vals gives inValid per cycle, cands the words sent on valid cycles.
   task automatic applyStimulus(input string name, input logic [WIDTH-1:0] r,
                                input logic [CW-1:0] cnt, input logic [WIDTH-1:0] cands[$],
                                input bit vals[$], input bit midStart, input int expLat);
      exp_t e;
      int   n;
      int   ci;
      int   xfers;
      int   cycles;
      bit   sawReady;
      bit   fire;
      logic [WIDTH-1:0] holdBest;
      n = (int'(cnt) > MAX_N) ? MAX_N : int'(cnt);
      @(negedge clk);
      start = 1'b1;
      refIn = r;
      count = cnt;
      expQ.push_back(model(r, n, cands));
      @(negedge clk);
      start    = 1'b0;
      cycles   = 1;
      ci       = 0;
      xfers    = 0;
      sawReady = 1'b0;
      for (int p = 0; p < vals.size(); p++) begin
         if (done) break;
         if (inReady) sawReady = 1'b1;
         inValid = vals[p];
         inData  = (vals[p] && ci < cands.size()) ? cands[ci] : 8'hA5;
         if (midStart && p == 1) begin
            start = 1'b1;
            refIn = ~r;
            count = CW'(1);
         end else begin
            start = 1'b0;
         end
         fire = inValid && inReady;
         @(negedge clk);
         cycles++;
         if (fire) begin
            xfers++;
            ci++;
         end
      end
      inValid = 1'b0;
      start   = 1'b0;
      for (int w = 0; w < 40 && !done; w++) begin
         if (inReady) sawReady = 1'b1;
         @(negedge clk);
         cycles++;
      end
      checkOutput({name, ".done"}, done, 1);
      e = expQ.pop_front();
      checkOutput({name, ".best"}, best, e.best);
      checkOutput({name, ".bestIdx"}, bestIdx, e.idx);
      checkOutput({name, ".found"}, found, e.found);
      checkOutput({name, ".busy"}, busy, 1);
      checkOutput({name, ".xfers"}, xfers, n);
      checkOutput({name, ".readySeen"}, sawReady, (n > 0) ? 1 : 0);
      if (expLat > 0) checkOutput({name, ".latency"}, cycles, expLat);
      holdBest = best;
      @(negedge clk);
      checkOutput({name, ".donePulse"}, done, 0);
      checkOutput({name, ".idleBusy"}, busy, 0);
      checkOutput({name, ".holdBest"}, best, e.best);
      checkOutput({name, ".holdFound"}, found, e.found);
      $display("[TB] %s finished, best=%0h held=%0h", name, best, holdBest);
   endtask

   initial begin
      logic [WIDTH-1:0] cq[$];
      bit               vq[$];
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      start   = 1'b0;
      refIn   = '0;
      count   = '0;
      inValid = 1'b0;
      inData  = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset.inReady", inReady, 0);
      checkOutput("reset.busy", busy, 0);
      checkOutput("reset.done", done, 0);
      checkOutput("reset.found", found, 0);
      checkOutput("reset.best", best, 0);
      checkOutput("reset.bestIdx", bestIdx, 0);
      rst = 1'b0;

      cq = '{8'h2E, 8'h0E, 8'h0F};       vq = '{1, 1, 1};
      applyStimulus("basic", 8'h0F, CW'(3), cq, vq, 1'b0, 4);
      cq = '{8'h0E, 8'h12};              vq = '{1, 1};
      applyStimulus("tie", 8'h10, CW'(2), cq, vq, 1'b0, 3);
      cq = '{8'h00, 8'hFE};              vq = '{1, 1};
      applyStimulus("extHigh", 8'hFF, CW'(2), cq, vq, 1'b0, 3);
      cq = '{8'hFF, 8'h01};              vq = '{1, 1};
      applyStimulus("extLow", 8'h00, CW'(2), cq, vq, 1'b0, 3);
      cq = '{};                          vq = '{1, 1};
      applyStimulus("zero", 8'h33, CW'(0), cq, vq, 1'b0, 1);

      // Later words are exact matches, so accepting more than MAX_N would change the winner.
      cq = '{};
      vq = '{};
      for (int i = 0; i < MAX_N + 5; i++) begin
         cq.push_back((i < MAX_N) ? 8'(8'h10 + i) : 8'h80);
         vq.push_back(1'b1);
      end
      applyStimulus("saturate", 8'h80, CW'(MAX_N + 5), cq, vq, 1'b0, MAX_N + 1);

      cq = '{8'h40, 8'h25, 8'h31};       vq = '{1, 0, 0, 1, 1};
      applyStimulus("backpressure", 8'h30, CW'(3), cq, vq, 1'b0, 6);
      cq = '{8'h90, 8'h70, 8'h7F};       vq = '{1, 1, 1};
      applyStimulus("midStart", 8'h80, CW'(3), cq, vq, 1'b1, 4);

      // Abort a 4-candidate search after two transfers; reset must clear outputs without a clock.
      @(negedge clk);
      start = 1'b1;
      refIn = 8'h20;
      count = CW'(4);
      @(negedge clk);
      start   = 1'b0;
      inValid = 1'b1;
      inData  = 8'h21;
      @(negedge clk);
      inData  = 8'h22;
      @(negedge clk);
      inValid = 1'b0;
      checkOutput("midScan.best", best, 8'h21);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst.inReady", inReady, 0);
      checkOutput("rst.busy", busy, 0);
      checkOutput("rst.done", done, 0);
      checkOutput("rst.found", found, 0);
      checkOutput("rst.best", best, 0);
      checkOutput("rst.bestIdx", bestIdx, 0);
      @(negedge clk);
      rst = 1'b0;
      cq = '{8'h50, 8'h52};              vq = '{1, 1};
      applyStimulus("afterReset", 8'h51, CW'(2), cq, vq, 1'b0, 3);

      checkOutput("queueEmpty", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

endmodule
